// File: rtl/ddr3_pattern_tester_if.sv
// rtl/ddr3_pattern_tester_if.sv - application-side command/write/read bus of the DDR3 controller
//   o_app_addr/o_app_cmd/o_app_en, i_app_rdy          : command channel
//   o_app_wdf_data/o_app_wdf_wren/o_app_wdf_end,
//   i_app_wdf_rdy                                      : write data channel
//   i_app_rd_data/i_app_rd_data_valid                  : read return channel
//   master = traffic generator, slave = controller
interface ddr3_pattern_tester_if #(
    parameter int ADDR_WIDTH = 28,
    parameter int DATA_WIDTH = 128
);
    logic [ADDR_WIDTH-1:0] o_app_addr;
    logic [2:0]            o_app_cmd;
    logic                  o_app_en;
    logic                  i_app_rdy;
    logic [DATA_WIDTH-1:0] o_app_wdf_data;
    logic                  o_app_wdf_wren;
    logic                  o_app_wdf_end;
    logic                  i_app_wdf_rdy;
    logic [DATA_WIDTH-1:0] i_app_rd_data;
    logic                  i_app_rd_data_valid;

    modport master (
        output o_app_addr, o_app_cmd, o_app_en, o_app_wdf_data, o_app_wdf_wren, o_app_wdf_end,
        input  i_app_rdy, i_app_wdf_rdy, i_app_rd_data, i_app_rd_data_valid
    );

    modport slave (
        input  o_app_addr, o_app_cmd, o_app_en, o_app_wdf_data, o_app_wdf_wren, o_app_wdf_end,
        output i_app_rdy, i_app_wdf_rdy, i_app_rd_data, i_app_rd_data_valid
    );
endinterface

// File: rtl/ddr3_pattern_tester.sv
// rtl/ddr3_pattern_tester.sv - DDR3 app-interface pattern writer / read-back checker
//   i_clk, i_rst_n       : UI clock, synchronous active-low reset
//   i_calib_done         : controller calibration complete
//   i_start              : one-cycle pulse, starts a test from IDLE or DONE
//   i_continuous         : keep looping passes while high
//   app                  : controller application bus (master side)
//   o_busy, o_done       : test running / test finished
//   o_error, o_err_addr  : sticky mismatch flag and first failing address
//   o_err_count          : saturating mismatch count
//   o_pass_count         : completed passes (wraps)
module ddr3_pattern_tester #(
    parameter int                    ADDR_WIDTH      = 28,
    parameter int                    DATA_WIDTH      = 128,
    parameter logic [ADDR_WIDTH-1:0] START_ADDR      = '0,
    parameter logic [ADDR_WIDTH-1:0] END_ADDR        = ADDR_WIDTH'(32'h0010_0000),
    parameter int                    ADDR_STEP       = 8,
    parameter int                    MAX_OUTSTANDING = 16
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_calib_done,
    input  logic                    i_start,
    input  logic                    i_continuous,
    ddr3_pattern_tester_if.master   app,
    output logic                    o_busy,
    output logic                    o_done,
    output logic                    o_error,
    output logic [ADDR_WIDTH-1:0]   o_err_addr,
    output logic [15:0]             o_err_count,
    output logic [15:0]             o_pass_count
);
    localparam int                    LANES     = DATA_WIDTH / 32;
    localparam int                    OS_W      = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [ADDR_WIDTH-1:0] STEP      = ADDR_WIDTH'(ADDR_STEP);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = END_ADDR - STEP;
    localparam logic [OS_W-1:0]       OS_MAX    = OS_W'(MAX_OUTSTANDING);

    typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN, S_DONE} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [ADDR_WIDTH-1:0] exp_addr;
    logic [15:0]           seed;
    logic [OS_W-1:0]       outstanding;
    logic                  cmd_done;
    logic                  dat_done;

    logic                  cmd_acc;
    logic                  dat_acc;
    logic                  cmd_fin;
    logic                  dat_fin;
    logic                  rd_acc;
    logic                  rd_ret;
    logic                  rd_bad;
    logic [OS_W-1:0]       os_next;
    logic [ADDR_WIDTH-1:0] next_addr;

    // Lane k carries {addr[27:0], k[3:0]} scrambled by the pass seed in both halves.
    function automatic logic [DATA_WIDTH-1:0] pattern(input logic [ADDR_WIDTH-1:0] addr,
                                                      input logic [15:0] sd);
        logic [DATA_WIDTH-1:0] d;
        logic [27:0]           a;
        d = '0;
        a = 28'(addr);
        for (int k = 0; k < LANES; k++) begin
            d[k*32 +: 32] = {a, 4'(k)} ^ {sd, sd};
        end
        return d;
    endfunction

    assign app.o_app_wdf_end = app.o_app_wdf_wren;

    always_comb begin
        cmd_acc   = app.o_app_en && app.i_app_rdy;
        dat_acc   = app.o_app_wdf_wren && app.i_app_wdf_rdy;
        // Command and data of a write burst complete independently; a side
        // counts as finished once accepted in this or any earlier cycle.
        cmd_fin   = cmd_done || cmd_acc;
        dat_fin   = dat_done || dat_acc;
        rd_acc    = cmd_acc && (state == S_READ);
        rd_ret    = app.i_app_rd_data_valid && (state == S_READ || state == S_DRAIN);
        rd_bad    = rd_ret && (app.i_app_rd_data != pattern(exp_addr, seed));
        os_next   = outstanding + OS_W'(rd_acc) - OS_W'(rd_ret);
        next_addr = cur_addr + STEP;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state              <= S_IDLE;
            cur_addr           <= '0;
            exp_addr           <= '0;
            seed               <= '0;
            outstanding        <= '0;
            cmd_done           <= 1'b0;
            dat_done           <= 1'b0;
            app.o_app_addr     <= '0;
            app.o_app_cmd      <= 3'b000;
            app.o_app_en       <= 1'b0;
            app.o_app_wdf_data <= '0;
            app.o_app_wdf_wren <= 1'b0;
            o_busy             <= 1'b0;
            o_done             <= 1'b0;
            o_error            <= 1'b0;
            o_err_addr         <= '0;
            o_err_count        <= '0;
            o_pass_count       <= '0;
        end else begin
            if (state == S_READ || state == S_DRAIN) begin
                outstanding <= os_next;
            end

            // Returns come back in issue order, so a running address tracks them.
            if (rd_ret) begin
                exp_addr <= exp_addr + STEP;
                if (rd_bad) begin
                    o_error <= 1'b1;
                    if (!o_error) begin
                        o_err_addr <= exp_addr;
                    end
                    if (o_err_count != 16'hFFFF) begin
                        o_err_count <= o_err_count + 16'd1;
                    end
                end
            end

            case (state)
                S_IDLE, S_DONE: begin
                    if (i_start && i_calib_done) begin
                        state              <= S_WRITE;
                        cur_addr           <= START_ADDR;
                        cmd_done           <= 1'b0;
                        dat_done           <= 1'b0;
                        app.o_app_addr     <= START_ADDR;
                        app.o_app_cmd      <= 3'b000;
                        app.o_app_en       <= 1'b1;
                        app.o_app_wdf_data <= pattern(START_ADDR, seed);
                        app.o_app_wdf_wren <= 1'b1;
                        o_busy             <= 1'b1;
                        o_done             <= 1'b0;
                    end
                end

                S_WRITE: begin
                    if (cmd_fin && dat_fin) begin
                        cmd_done <= 1'b0;
                        dat_done <= 1'b0;
                        if (cur_addr == LAST_ADDR) begin
                            state              <= S_READ;
                            cur_addr           <= START_ADDR;
                            exp_addr           <= START_ADDR;
                            app.o_app_addr     <= START_ADDR;
                            app.o_app_cmd      <= 3'b001;
                            app.o_app_en       <= 1'b1;
                            app.o_app_wdf_wren <= 1'b0;
                        end else begin
                            cur_addr           <= next_addr;
                            app.o_app_addr     <= next_addr;
                            app.o_app_en       <= 1'b1;
                            app.o_app_wdf_data <= pattern(next_addr, seed);
                            app.o_app_wdf_wren <= 1'b1;
                        end
                    end else begin
                        cmd_done           <= cmd_fin;
                        dat_done           <= dat_fin;
                        app.o_app_en       <= !cmd_fin;
                        app.o_app_wdf_wren <= !dat_fin;
                    end
                end

                S_READ: begin
                    if (rd_acc && cur_addr == LAST_ADDR) begin
                        state        <= S_DRAIN;
                        app.o_app_en <= 1'b0;
                    end else begin
                        if (rd_acc) begin
                            cur_addr       <= next_addr;
                            app.o_app_addr <= next_addr;
                        end
                        // An unaccepted command cannot raise the count, so a
                        // held request stays asserted here.
                        app.o_app_en <= (os_next < OS_MAX);
                    end
                end

                S_DRAIN: begin
                    if (outstanding == '0) begin
                        o_pass_count <= o_pass_count + 16'd1;
                        if (i_continuous) begin
                            state              <= S_WRITE;
                            seed               <= seed + 16'd1;
                            cur_addr           <= START_ADDR;
                            cmd_done           <= 1'b0;
                            dat_done           <= 1'b0;
                            app.o_app_addr     <= START_ADDR;
                            app.o_app_cmd      <= 3'b000;
                            app.o_app_en       <= 1'b1;
                            app.o_app_wdf_data <= pattern(START_ADDR, seed + 16'd1);
                            app.o_app_wdf_wren <= 1'b1;
                        end else begin
                            state  <= S_DONE;
                            o_busy <= 1'b0;
                            o_done <= 1'b1;
                        end
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ddr3_pattern_tester.sv
// tb/tb_ddr3_pattern_tester.sv - scoreboard bench for ddr3_pattern_tester with a controller model
module tb_ddr3_pattern_tester;
    localparam int             AW   = 28;
    localparam int             DW   = 128;
    localparam int             MAXO = 4;
    localparam logic [AW-1:0]  SA   = 28'h0;
    localparam logic [AW-1:0]  EA   = 28'h40;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n = 1'b0;
    logic          calib = 1'b0;
    logic          start = 1'b0;
    logic          cont  = 1'b0;
    logic          busy, done, err;
    logic [AW-1:0] err_addr;
    logic [15:0]   err_cnt, pass_cnt;

    ddr3_pattern_tester_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) app_bus ();

    ddr3_pattern_tester #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .START_ADDR(SA), .END_ADDR(EA),
        .ADDR_STEP(8), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_calib_done(calib), .i_start(start),
        .i_continuous(cont), .app(app_bus), .o_busy(busy), .o_done(done),
        .o_error(err), .o_err_addr(err_addr), .o_err_count(err_cnt), .o_pass_count(pass_cnt)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: event missing or unexpected", name);
    endtask

    function automatic logic [DW-1:0] tb_pat(input logic [AW-1:0] a, input logic [15:0] s);
        logic [DW-1:0] p;
        p = '0;
        for (int k = 0; k < 4; k++) p[32*k +: 32] = {a[27:0], 4'(k)} ^ {s, s};
        return p;
    endfunction

    // controller model state
    typedef struct { longint due; logic [AW-1:0] addr; } rd_t;
    rd_t            rd_pend[$];
    logic [AW-1:0]  exp_wa_q[$];
    logic [DW-1:0]  exp_wd_q[$];
    logic [AW-1:0]  exp_ra_q[$];
    logic [AW-1:0]  wc_q[$];
    logic [DW-1:0]  wd_q[$];
    logic [DW-1:0]  mem [logic [AW-1:0]];
    longint         cyc = 0;
    int             lat = 10;
    bit             rand_rdy = 0;
    bit             stall_en = 0;
    bit             inject = 0;
    bit             corrupt_en = 0;
    logic [AW-1:0]  corrupt_addr = '0;
    int             wdata_acc = 0;
    int             stall_cnt = 0;
    int             max_out = 0;

    // driver: decides controller inputs for the next rising edge
    initial begin
        rd_t           r;
        logic [DW-1:0] d;
        app_bus.i_app_rdy           = 1'b0;
        app_bus.i_app_wdf_rdy       = 1'b0;
        app_bus.i_app_rd_data       = '0;
        app_bus.i_app_rd_data_valid = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            app_bus.i_app_rdy = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            if (stall_en && wdata_acc == 2 && stall_cnt < 5) begin
                app_bus.i_app_wdf_rdy = 1'b0;
                stall_cnt++;
            end else begin
                app_bus.i_app_wdf_rdy = 1'b1;
            end
            if (inject) begin
                app_bus.i_app_rd_data_valid = 1'b1;
                app_bus.i_app_rd_data       = '1;
            end else if (rd_pend.size() > 0 && rd_pend[0].due <= cyc) begin
                r = rd_pend.pop_front();
                d = mem.exists(r.addr) ? mem[r.addr] : '0;
                if (corrupt_en && r.addr == corrupt_addr) d[0] = ~d[0];
                app_bus.i_app_rd_data_valid = 1'b1;
                app_bus.i_app_rd_data       = d;
            end else begin
                app_bus.i_app_rd_data_valid = 1'b0;
            end
        end
    end

    // monitor: handshakes that complete at the coming edge, compared against the scoreboard
    initial begin
        bit            en_pend = 0, wr_pend = 0;
        logic [AW-1:0] h_addr;
        logic [2:0]    h_cmd;
        logic [DW-1:0] h_data;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                en_pend = 0;
                wr_pend = 0;
            end else begin
                if (en_pend) begin
                    check("cmd_hold_en", 128'(app_bus.o_app_en), 128'(1));
                    check("cmd_hold_addr", 128'(app_bus.o_app_addr), 128'(h_addr));
                    check("cmd_hold_cmd", 128'(app_bus.o_app_cmd), 128'(h_cmd));
                end
                if (wr_pend) begin
                    check("wdf_hold_wren", 128'(app_bus.o_app_wdf_wren), 128'(1));
                    check("wdf_hold_data", app_bus.o_app_wdf_data, h_data);
                end
                if (app_bus.o_app_en && app_bus.i_app_rdy) begin
                    if (app_bus.o_app_cmd == 3'b000) begin
                        if (exp_wa_q.size() == 0) fail_now("unexpected_write_cmd");
                        else check("wr_addr", 128'(app_bus.o_app_addr), 128'(exp_wa_q.pop_front()));
                        wc_q.push_back(app_bus.o_app_addr);
                    end else begin
                        if (exp_ra_q.size() == 0) fail_now("unexpected_read_cmd");
                        else check("rd_addr", 128'(app_bus.o_app_addr), 128'(exp_ra_q.pop_front()));
                        check("rd_cmd", 128'(app_bus.o_app_cmd), 128'(3'b001));
                        rd_pend.push_back('{cyc + longint'(lat), app_bus.o_app_addr});
                        if (rd_pend.size() > max_out) max_out = rd_pend.size();
                    end
                end
                if (app_bus.o_app_wdf_wren && app_bus.i_app_wdf_rdy) begin
                    check("wdf_end", 128'(app_bus.o_app_wdf_end), 128'(1));
                    if (exp_wd_q.size() == 0) fail_now("unexpected_write_data");
                    else check("wr_data", app_bus.o_app_wdf_data, exp_wd_q.pop_front());
                    wd_q.push_back(app_bus.o_app_wdf_data);
                    wdata_acc++;
                end
                while (wc_q.size() > 0 && wd_q.size() > 0) mem[wc_q.pop_front()] = wd_q.pop_front();
                en_pend = app_bus.o_app_en && !app_bus.i_app_rdy;
                wr_pend = app_bus.o_app_wdf_wren && !app_bus.i_app_wdf_rdy;
                h_addr  = app_bus.o_app_addr;
                h_cmd   = app_bus.o_app_cmd;
                h_data  = app_bus.o_app_wdf_data;
            end
        end
    end

    task automatic push_pass(input logic [15:0] s);
        for (int a = 0; a < 64; a += 8) begin
            exp_wa_q.push_back(AW'(a));
            exp_wd_q.push_back(tb_pat(AW'(a), s));
            exp_ra_q.push_back(AW'(a));
        end
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!done) fail_now("done_timeout");
    endtask

    task automatic check_queues();
        check("wr_q_drained", 128'(exp_wa_q.size()), 128'(0));
        check("rd_q_drained", 128'(exp_ra_q.size()), 128'(0));
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("reset_status", {busy, done, err, err_addr, err_cnt, pass_cnt}, '0);
        check("reset_app", {app_bus.o_app_en, app_bus.o_app_wdf_wren, app_bus.o_app_wdf_end,
                            app_bus.o_app_addr, app_bus.o_app_cmd, app_bus.o_app_wdf_data}, '0);
        exp_wa_q.delete(); exp_wd_q.delete(); exp_ra_q.delete();
        wc_q.delete(); wd_q.delete();
        @(posedge clk); #1 rst_n = 1'b1;
    endtask

    initial begin
        logic [AW-1:0] k08, k00;
        int            n;
        k08 = 28'h8;
        k00 = 28'h0;

        do_reset();

        // start without calibration is dropped and not remembered
        pulse_start();
        repeat (3) @(negedge clk);
        check("nocal_busy", 128'(busy), 128'(0));
        check("nocal_en", 128'(app_bus.o_app_en), 128'(0));
        calib = 1'b1;
        repeat (3) @(negedge clk);
        check("nocal_not_remembered", 128'(busy), 128'(0));

        // ideal controller, 10-cycle latency
        max_out = 0;
        push_pass(16'h0);
        pulse_start();
        wait_done(2000);
        check("t1_done", 128'(done), 128'(1));
        check("t1_busy", 128'(busy), 128'(0));
        check("t1_error", 128'(err), 128'(0));
        check("t1_pass", 128'(pass_cnt), 128'(1));
        check("t1_lane1_at_08", 128'(mem[k08][63:32]), 128'(32'h0000_0081));
        check("t1_max_out_le4", 128'(max_out <= MAXO), 128'(1));
        check_queues();

        // corrupted return at 0x18
        corrupt_en = 1; corrupt_addr = 28'h18;
        push_pass(16'h0);
        pulse_start();
        wait_done(2000);
        corrupt_en = 0;
        check("t2_error", 128'(err), 128'(1));
        check("t2_err_addr", 128'(err_addr), 128'(28'h18));
        check("t2_err_count", 128'(err_cnt), 128'(1));
        check("t2_pass", 128'(pass_cnt), 128'(2));
        check_queues();

        // random command ready, write data stalled on the third burst
        do_reset();
        rand_rdy = 1; stall_en = 1; wdata_acc = 0; stall_cnt = 0;
        push_pass(16'h0);
        pulse_start();
        wait_done(4000);
        rand_rdy = 0; stall_en = 0;
        check("t3_error", 128'(err), 128'(0));
        check("t3_pass", 128'(pass_cnt), 128'(1));
        check_queues();

        // long latency saturates the outstanding limit
        do_reset();
        lat = 40; max_out = 0;
        push_pass(16'h0);
        pulse_start();
        wait_done(5000);
        lat = 10;
        check("t4_max_out", 128'(max_out), 128'(MAXO));
        check("t4_error", 128'(err), 128'(0));
        check("t4_pass", 128'(pass_cnt), 128'(1));
        check_queues();

        // continuous passes with incrementing seed
        do_reset();
        cont = 1'b1;
        for (int s = 0; s < 4; s++) push_pass(16'(s));
        pulse_start();
        n = 0;
        while (pass_cnt != 16'd3 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (pass_cnt != 16'd3) fail_now("t5_third_pass_timeout");
        cont = 1'b0;
        wait_done(2000);
        check("t5_pass", 128'(pass_cnt), 128'(4));
        check("t5_error", 128'(err), 128'(0));
        check("t5_seed3_lane0", 128'(mem[k00][31:0]), 128'(32'h0003_0003));
        check_queues();

        // reset while reads are in flight; late returns in IDLE are ignored
        do_reset();
        push_pass(16'h0);
        pulse_start();
        n = 0;
        while (!(app_bus.o_app_en && app_bus.o_app_cmd == 3'b001 && app_bus.i_app_rdy) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) fail_now("t6_read_timeout");
        do_reset();
        @(posedge clk); #1 inject = 1;
        repeat (2) @(posedge clk);
        #1 inject = 0;
        repeat (30) @(negedge clk);
        check("t6_idle_error", 128'(err), 128'(0));
        check("t6_idle_err_count", 128'(err_cnt), 128'(0));
        check("t6_idle_busy", 128'(busy), 128'(0));
        push_pass(16'h0);
        pulse_start();
        wait_done(2000);
        check("t6_error", 128'(err), 128'(0));
        check("t6_pass", 128'(pass_cnt), 128'(1));
        check_queues();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/ddr3_pattern_tester.md
Name: ddr3_pattern_tester

Overview:
- Traffic generator and checker on the user side of the DDR3 controller, clocked by the controller's UI clock.
- Writes an address-derived pattern over a configurable address range, then reads the range back and compares each burst.
- Reports a sticky compare error, the first failing address, an error count and a pass count; top level drives tg_compare_error and the board LEDs from these.
- Replaces the constant tie-offs on the controller's application interface.

Parameters:
- ADDR_WIDTH, 28, controller app address width
- DATA_WIDTH, 128, controller app data width; must be a multiple of 32
- START_ADDR, 28'h0, first burst address (inclusive), multiple of ADDR_STEP
- END_ADDR, 28'h0100000, end address (exclusive), multiple of ADDR_STEP, > START_ADDR
- ADDR_STEP, 8, address increment per 128-bit burst (x16, BL8)
- MAX_OUTSTANDING, 16, maximum read commands accepted but not yet returned

Ports:
- i_clk, input, 1, UI clock from controller (ui_clk)
- i_rst_n, input, 1, synchronous active-low reset; top level drives it from ~ui_clk_sync_rst
- i_calib_done, input, 1, controller init_calib_complete
- i_start, input, 1, one-cycle pulse; starts a test from IDLE
- i_continuous, input, 1, loop passes while high
- o_app_addr, output, ADDR_WIDTH, controller command address
- o_app_cmd, output, 3, 3'b000 write, 3'b001 read
- o_app_en, output, 1, command valid
- i_app_rdy, input, 1, command accepted when o_app_en && i_app_rdy
- o_app_wdf_data, output, DATA_WIDTH, write data
- o_app_wdf_wren, output, 1, write data valid
- o_app_wdf_end, output, 1, equals o_app_wdf_wren (one beat per burst)
- i_app_wdf_rdy, input, 1, data accepted when o_app_wdf_wren && i_app_wdf_rdy
- i_app_rd_data, input, DATA_WIDTH, read data
- i_app_rd_data_valid, input, 1, read data valid
- o_busy, output, 1, high outside IDLE/DONE
- o_done, output, 1, high in DONE
- o_error, output, 1, sticky mismatch flag
- o_err_addr, output, ADDR_WIDTH, address of first mismatch
- o_err_count, output, 16, mismatch count, saturates at 16'hFFFF
- o_pass_count, output, 16, completed passes, wraps

Behaviour:
- Reset (i_rst_n low at a clock edge): state IDLE; all outputs 0; seed 0; outstanding counter 0. Applies mid-operation; commands in flight are abandoned.
- Pattern: 32-bit lane k = {addr[27:0], k[3:0]} XOR {seed[15:0], seed[15:0]}.
- IDLE: o_busy 0. Goes to WRITE when i_start && i_calib_done. i_start without calibration is ignored, not remembered.
- WRITE:
  - Presents o_app_cmd=000, o_app_addr=cur, and pattern(cur) on data.
  - Command and data are tracked independently. o_app_en is held until accepted. o_app_wdf_wren is held until accepted.
  - Either side may complete first. The next address is presented the cycle after both have completed.
  - After the burst at END_ADDR-ADDR_STEP completes: cur=START_ADDR, go to READ.
- READ:
  - Issues o_app_cmd=001 at cur while outstanding < MAX_OUTSTANDING. o_app_en is held until i_app_rdy.
  - Issue counter increments on accept. Outstanding: +1 on accept, -1 on valid, unchanged on simultaneous accept and valid.
  - After the last address is accepted, o_app_en drops and state goes to DRAIN.
- Checking (READ and DRAIN):
  - Returns are in order. The expected-address counter starts at START_ADDR and advances by ADDR_STEP per valid.
  - On mismatch: o_error set. o_err_addr captured only if o_error was 0. o_err_count increments (saturating).
  - i_app_rd_data_valid is ignored in all other states.
- DRAIN: when outstanding reaches 0:
  - o_pass_count increments.
  - If i_continuous: seed+1, cur=START_ADDR, go to WRITE.
  - Otherwise go to DONE.
- DONE: o_done 1. i_start returns to WRITE. o_error, o_err_addr and o_err_count are kept; clear only on reset.
- Loss of i_calib_done mid-test is not handled; it requires reset.
- Throughput target: one command per cycle when i_app_rdy is held high.

Test Plan:
- Ideal controller model (rdy always 1, 10-cycle read latency), START 0, END 0x40, i_start → 8 write bursts at 0x00..0x38, then 8 reads; o_done=1, o_error=0, o_pass_count=1; data at 0x08 lane 1 = 32'h0000_0081.
- Model corrupts bit 0 of the read at 0x18 → o_error=1, o_err_addr=0x18, o_err_count=1; all 8 reads still complete.
- i_app_rdy toggled randomly, i_app_wdf_rdy low for 5 cycles on the 3rd burst → en/wren and data stay stable until accepted; no duplicated or skipped address; pass clean.
- Read latency 40 cycles, MAX_OUTSTANDING=4 → never more than 4 unreturned reads; simultaneous accept and return keeps the count unchanged.
- i_continuous=1 for 3 passes → o_pass_count=3, seed=3 on the 4th pass; drop i_continuous → DONE after the current pass.
- i_rst_n low during READ → all outputs 0 next cycle; late rd_data_valid in IDLE is ignored; a new i_start passes cleanly.
